// File: rtl/kernel_launcher_pkg.sv
// Shared types and register map for the kernel launch controller.
// The host register addresses and bit positions are the software-visible contract.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ABORT = 2'd3
  } launcher_state_t;

  // Remembers why the ABORT state was entered so the right sticky bit is set on exit.
  typedef enum logic {
    CAUSE_HOST = 1'b0,
    CAUSE_WDOG = 1'b1
  } abort_cause_t;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_THREAD_COUNT = 2'd0;
  localparam reg_addr_t ADDR_CONTROL      = 2'd1;
  localparam reg_addr_t ADDR_STATUS       = 2'd2;
  localparam reg_addr_t ADDR_RESERVED     = 2'd3;

  localparam int CTRL_GO         = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_CLR_STATUS = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_WR_ERR  = 4;
  localparam int STAT_WIDTH   = 5;

  // BUSY is live state; everything above it is sticky.
  function automatic logic [STAT_WIDTH-1:0] pack_status(
    input logic [STAT_WIDTH-1:1] sticky,
    input logic                  busy
  );
    return {sticky, busy};
  endfunction

endpackage

// File: rtl/kernel_launcher_if.sv
// Host register bus plus dispatcher handshake of the kernel launcher.
// master = host/dispatcher side, slave = launcher side.
interface kernel_launcher_if #(
  parameter int TC_WIDTH  = 8,
  parameter int CYC_WIDTH = 32
);
  import gpu_pkg::*;

  logic                 host_wr_en;
  reg_addr_t            host_addr;
  logic [TC_WIDTH-1:0]  host_wdata;
  logic [TC_WIDTH-1:0]  host_rdata;

  logic                 disp_done;
  logic [TC_WIDTH-1:0]  disp_thread_count;
  logic                 disp_start;
  logic                 disp_reset_n;

  logic [CYC_WIDTH-1:0] run_cycles;
  logic                 irq;

  modport master (
    output host_wr_en, host_addr, host_wdata, disp_done,
    input  host_rdata, disp_thread_count, disp_start, disp_reset_n, run_cycles, irq
  );

  modport slave (
    input  host_wr_en, host_addr, host_wdata, disp_done,
    output host_rdata, disp_thread_count, disp_start, disp_reset_n, run_cycles, irq
  );

endinterface

// File: rtl/kernel_launcher_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats enable.
// Used to time how long a kernel spends in RUN.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/kernel_launcher.sv
// Launch controller in front of the block dispatcher: host registers, start/hold
// protocol, run timing, optional watchdog and a one-cycle completion interrupt.
module kernel_launcher
  import gpu_pkg::*;
#(
  parameter int TC_WIDTH       = 8,
  parameter int CYC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  kernel_launcher_if.slave bus
);

  localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CYC_WIDTH-1:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ?
                                               CYC_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  launcher_state_t         state_q,  state_d;
  logic [TC_WIDTH-1:0]     tc_q,     tc_d;
  logic [STAT_WIDTH-1:1]   sticky_q, sticky_d;
  abort_cause_t            cause_q,  cause_d;
  logic                    irq_q,    irq_d;

  logic                    busy;
  logic                    wr_tc;
  logic                    wr_ctrl;
  logic                    go_req;
  logic                    abort_req;
  logic                    clr_req;
  logic                    wdog_hit;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic [CYC_WIDTH-1:0]    run_cycles;
  logic [TC_WIDTH-1:0]     status_word;

  assign busy      = (state_q != IDLE);
  assign wr_tc     = bus.host_wr_en && (bus.host_addr == ADDR_THREAD_COUNT);
  assign wr_ctrl   = bus.host_wr_en && (bus.host_addr == ADDR_CONTROL);
  assign go_req    = wr_ctrl && bus.host_wdata[CTRL_GO];
  assign abort_req = wr_ctrl && bus.host_wdata[CTRL_ABORT];
  assign clr_req   = wr_ctrl && bus.host_wdata[CTRL_CLR_STATUS];
  assign wdog_hit  = WDOG_EN && (run_cycles == WDOG_LAST);
  assign cnt_en    = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    tc_d     = tc_q;
    sticky_d = sticky_q;
    cause_d  = cause_q;
    irq_d    = 1'b0;
    cnt_clr  = 1'b0;

    if (clr_req) begin
      sticky_d = '0;
    end

    // The thread count is frozen for the whole run; late writes are flagged instead.
    if (wr_tc) begin
      if (busy) begin
        sticky_d[STAT_WR_ERR] = 1'b1;
      end else begin
        tc_d = bus.host_wdata;
      end
    end

    if (go_req && busy) begin
      sticky_d[STAT_WR_ERR] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (go_req) begin
          sticky_d = '0;
          cnt_clr  = 1'b1;
          if (tc_q != '0) begin
            state_d = RUN;
          end else begin
            sticky_d[STAT_DONE] = 1'b1;
            irq_d               = 1'b1;
          end
        end
      end
      RUN: begin
        // Completion outranks a racing host abort, which outranks the watchdog.
        if (bus.disp_done) begin
          state_d = DRAIN;
        end else if (abort_req) begin
          state_d = ABORT;
          cause_d = CAUSE_HOST;
        end else if (wdog_hit) begin
          state_d = ABORT;
          cause_d = CAUSE_WDOG;
        end
      end
      DRAIN: begin
        if (!bus.disp_done) begin
          state_d             = IDLE;
          sticky_d[STAT_DONE] = 1'b1;
          irq_d               = 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        irq_d   = 1'b1;
        if (cause_q == CAUSE_WDOG) begin
          sticky_d[STAT_TIMEOUT] = 1'b1;
        end else begin
          sticky_d[STAT_ABORTED] = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tc_q     <= '0;
      sticky_q <= '0;
      cause_q  <= CAUSE_HOST;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      sticky_q <= sticky_d;
      cause_q  <= cause_d;
      irq_q    <= irq_d;
    end
  end

  sat_counter #(
    .WIDTH (CYC_WIDTH)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (run_cycles)
  );

  assign status_word = TC_WIDTH'(pack_status(sticky_q, busy));

  always_comb begin
    bus.host_rdata = '0;
    case (bus.host_addr)
      ADDR_THREAD_COUNT: bus.host_rdata = tc_q;
      ADDR_STATUS:       bus.host_rdata = status_word;
      default:           bus.host_rdata = '0;
    endcase
  end

  // Dispatcher outputs decode straight from state so an async reset drops them at once.
  assign bus.disp_thread_count = tc_q;
  assign bus.disp_start        = (state_q == RUN);
  assign bus.disp_reset_n      = (state_q != ABORT);
  assign bus.run_cycles        = run_cycles;
  assign bus.irq               = irq_q;

endmodule

// File: tb/tb_kernel_launcher.sv
// Randomized self-checking bench for kernel_launcher: each launch is predicted as a
// whole (which event ends it, when, and what the host then reads) from the register rules.
module tb_kernel_launcher;

  localparam int TCW = 8;
  localparam int CW  = 32;
  localparam int TMO = 24;

  localparam logic [1:0] A_TC   = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_RSVD = 2'd3;

  logic clk;
  logic rst_n;
  int unsigned err_cnt;
  int unsigned chk_cnt;

  kernel_launcher_if #(.TC_WIDTH(TCW), .CYC_WIDTH(CW)) bus ();

  kernel_launcher #(
    .TC_WIDTH       (TCW),
    .CYC_WIDTH      (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    bus.host_wr_en = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
    bus.host_wr_en = 1'b0;
    bus.host_addr  = A_STAT;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.host_wr_en = 1'b0;
    bus.host_addr  = a;
    #1;
    check_eq(tag, 32'(bus.host_rdata), 32'(exp));
    bus.host_addr  = A_STAT;
  endtask

  // done_at/abort_at/err_at: RUN-cycle index (0 = first cycle disp_start is high), -1 = none.
  task automatic run_kernel(input int tc, input int done_at, input int abort_at, input int err_at);
    int e;
    int kind;
    bit do_abort;
    bit do_err;
    logic [7:0] exp_st;
    logic [7:0] go_val;
    int irq_n, irq_at, rn_n, rn_at, start_n;

    // Which event ends the run: done beats abort beats watchdog on the same cycle.
    e    = TMO - 1;
    kind = 2;
    if (abort_at >= 0 && abort_at <= e) begin e = abort_at; kind = 1; end
    if (done_at  >= 0 && done_at  <= e) begin e = done_at;  kind = 0; end
    do_abort = (abort_at >= 0) && ((abort_at <= e) || (kind == 0 && abort_at == e + 1));
    do_err   = (err_at >= 0) && (err_at + 1 < e) &&
               !(do_abort && (abort_at == err_at || abort_at == err_at + 1));
    exp_st   = (kind == 0) ? 8'h02 : (kind == 1) ? 8'h04 : 8'h08;
    if (do_err) exp_st = exp_st | 8'h10;

    // GO may carry CLR_STATUS and junk upper bits; in IDLE only GO matters.
    go_val = 8'($urandom_range(0, 255)) | 8'h01;
    host_write(A_TC, 8'(tc));
    host_write(A_CTRL, go_val);

    if (tc == 0) begin
      check_eq("zero_tc_irq", 32'(bus.irq), 32'd1);
      check_eq("zero_tc_start", 32'(bus.disp_start), 32'd0);
      check_eq("zero_tc_cycles", bus.run_cycles, 32'd0);
      read_check("zero_tc_status", A_STAT, 8'h02);
      tick();
      check_eq("zero_tc_irq_off", 32'(bus.irq), 32'd0);
      $display("launch tc=0 -> immediate DONE status=0x02");
      return;
    end

    check_eq("start_rise", 32'(bus.disp_start), 32'd1);
    check_eq("thread_count", 32'(bus.disp_thread_count), 32'(tc));
    check_eq("cycles_start", bus.run_cycles, 32'd0);

    irq_n = 0; irq_at = -1; rn_n = 0; rn_at = -1; start_n = 0;
    for (int k = 0; k < e + 6; k++) begin
      if (bus.disp_start) start_n++;
      if (bus.irq) begin irq_n++; irq_at = k; end
      if (!bus.disp_reset_n) begin rn_n++; rn_at = k; end

      bus.disp_done  = (kind == 0) && (k == done_at);
      bus.host_wr_en = 1'b0;
      bus.host_addr  = A_STAT;
      if (do_abort && k == abort_at) begin
        bus.host_wr_en = 1'b1; bus.host_addr = A_CTRL; bus.host_wdata = 8'h02;
      end else if (do_err && k == err_at) begin
        bus.host_wr_en = 1'b1; bus.host_addr = A_TC; bus.host_wdata = 8'($urandom_range(0, 255));
      end else if (do_err && k == err_at + 1) begin
        bus.host_wr_en = 1'b1; bus.host_addr = A_CTRL;
        bus.host_wdata = (8'($urandom_range(0, 255)) & 8'hF8) | 8'h01;
      end
      if (k == e && !bus.host_wr_en) begin
        #1;
        check_eq("busy_status", 32'(bus.host_rdata), do_err ? 32'h11 : 32'h01);
      end
      tick();
    end
    bus.disp_done  = 1'b0;
    bus.host_wr_en = 1'b0;

    check_eq("start_cycles", 32'(start_n), 32'(e + 1));
    check_eq("irq_count", 32'(irq_n), 32'd1);
    check_eq("irq_when", 32'(irq_at), 32'(e + 2));
    check_eq("rstn_count", 32'(rn_n), (kind == 0) ? 32'd0 : 32'd1);
    check_eq("rstn_when", 32'(rn_at), (kind == 0) ? 32'hFFFF_FFFF : 32'(e + 1));
    check_eq("run_cycles", bus.run_cycles, 32'(e + 1));
    check_eq("tc_frozen", 32'(bus.disp_thread_count), 32'(tc));
    read_check("end_status", A_STAT, exp_st);
    $display("launch tc=%0d done_at=%0d abort_at=%0d err_at=%0d -> end=%0d kind=%0d status=0x%0h",
             tc, done_at, abort_at, err_at, e, kind, exp_st);
  endtask

  initial begin
    int tc, d, a, w;
    err_cnt = 0;
    chk_cnt = 0;
    rst_n          = 1'b0;
    bus.host_wr_en = 1'b0;
    bus.host_addr  = A_STAT;
    bus.host_wdata = '0;
    bus.disp_done  = 1'b0;

    #3;
    check_eq("rst_start", 32'(bus.disp_start), 32'd0);
    check_eq("rst_rstn", 32'(bus.disp_reset_n), 32'd1);
    check_eq("rst_irq", 32'(bus.irq), 32'd0);
    check_eq("rst_cycles", bus.run_cycles, 32'd0);
    check_eq("rst_tc", 32'(bus.disp_thread_count), 32'd0);
    read_check("rst_status", A_STAT, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed launches: normal finish, zero count, watchdog, host abort with late writes,
    // done racing abort, abort landing in DRAIN.
    run_kernel(10, 14, -1, -1);
    run_kernel(0, -1, -1, -1);
    run_kernel(7, -1, -1, -1);
    run_kernel(12, -1, 9, 3);
    run_kernel(9, 5, 5, -1);
    run_kernel(33, 6, 7, 1);
    run_kernel(200, 23, -1, -1);

    // Idle-side register behaviour; status currently holds DONE.
    host_write(A_CTRL, 8'h02);
    check_eq("idle_abort_rstn", 32'(bus.disp_reset_n), 32'd1);
    check_eq("idle_abort_start", 32'(bus.disp_start), 32'd0);
    read_check("idle_abort_status", A_STAT, 8'h02);
    bus.disp_done = 1'b1;
    tick();
    bus.disp_done = 1'b0;
    check_eq("spurious_done_start", 32'(bus.disp_start), 32'd0);
    check_eq("spurious_done_irq", 32'(bus.irq), 32'd0);
    read_check("spurious_done_status", A_STAT, 8'h02);
    read_check("ctrl_reads_zero", A_CTRL, 8'h00);
    read_check("rsvd_reads_zero", A_RSVD, 8'h00);
    host_write(A_TC, 8'h5A);
    read_check("tc_readback", A_TC, 8'h5A);
    host_write(A_CTRL, 8'h04);
    read_check("clr_status", A_STAT, 8'h00);

    for (int i = 0; i < 24; i++) begin
      tc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      d  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 30));
      a  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30));
      w  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 20));
      run_kernel(tc, d, a, w);
    end

    // Asynchronous reset in the middle of a run, then a clean relaunch.
    host_write(A_TC, 8'd20);
    host_write(A_CTRL, 8'h01);
    tick();
    tick();
    bus.host_addr = A_STAT;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_start", 32'(bus.disp_start), 32'd0);
    check_eq("mid_rst_status", 32'(bus.host_rdata), 32'd0);
    check_eq("mid_rst_cycles", bus.run_cycles, 32'd0);
    check_eq("mid_rst_rstn", 32'(bus.disp_reset_n), 32'd1);
    check_eq("mid_rst_tc", 32'(bus.disp_thread_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("async reset mid-run -> outputs cleared");
    run_kernel(4, 14, -1, -1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/kernel_launcher.md
Name: kernel_launcher

Overview:
- Host-facing launch controller directly upstream of the block dispatcher.
- Holds the kernel thread count register and drives the dispatcher's thread_count/start pair with the exact hold-then-release protocol the dispatcher expects.
- Times the run with a cycle counter, enforces an optional watchdog, and reports completion, abort and errors through a small register file plus an interrupt pulse.

Parameters:
- TC_WIDTH, 8, width of thread count register and dispatcher thread_count.
- CYC_WIDTH, 32, width of run cycle counter.
- TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- host_wr_en  in  1  single-cycle register write strobe.
- host_addr  in  2  register select: 0 THREAD_COUNT, 1 CONTROL (write-only), 2 STATUS, 3 reserved.
- host_wdata  in  TC_WIDTH  write data.
- host_rdata  out  TC_WIDTH  combinational read data for host_addr; CONTROL and reserved read 0.
- disp_done  in  1  dispatcher done.
- disp_thread_count  out  TC_WIDTH  thread count to dispatcher; frozen while not IDLE.
- disp_start  out  1  level start to dispatcher.
- disp_reset_n  out  1  active-low reset to dispatcher; low exactly 1 cycle on abort/timeout.
- run_cycles  out  CYC_WIDTH  cycles spent in RUN for last/current kernel, saturating.
- irq  out  1  one-cycle pulse on any run termination (done, abort, timeout).

Behaviour:
- Reset (asynchronous, active-low): state IDLE, thread count reg 0, STATUS 0, disp_start 0, disp_reset_n 1, run_cycles 0, irq 0.
- Clock and reset are the only timing inputs: one clock domain; reset polarity and asynchronous behaviour are fixed.
- CONTROL write bits: [0] GO, [1] ABORT, [2] CLR_STATUS. Other bits are ignored.
- STATUS bits: [0] BUSY (state != IDLE), [1] DONE, [2] ABORTED, [3] TIMEOUT, [4] WR_ERR. Bits [4:1] are sticky until CLR_STATUS or the next accepted GO.
- State machine:
  - IDLE
    - GO with thread count != 0: at the next edge go to RUN, disp_start=1, run_cycles=0, STATUS[4:1]=0. disp_start is high one cycle after the write cycle.
    - GO with thread count == 0: stay IDLE, set DONE, pulse irq next cycle, run_cycles=0, no start.
  - RUN
    - disp_start=1; run_cycles increments each cycle, saturating at all-ones.
    - disp_done=1: go to DRAIN, disp_start=0 at next edge.
    - ABORT or watchdog: go to ABORT.
  - DRAIN
    - disp_start=0; wait for disp_done=0, which the dispatcher guarantees one cycle later.
    - Then go to IDLE, set DONE, pulse irq.
  - ABORT
    - One cycle: disp_reset_n=0, disp_start=0.
    - Next edge: go to IDLE, set ABORTED (host) or TIMEOUT (watchdog), pulse irq.
- Watchdog: when TIMEOUT_CYCLES != 0 and run_cycles == TIMEOUT_CYCLES-1 in RUN, go to ABORT at the next edge.
- Priority within RUN: disp_done > ABORT > watchdog. A kernel that completes on the same cycle as an abort reports DONE.
- Writes while BUSY:
  - THREAD_COUNT write is ignored and sets WR_ERR.
  - GO is ignored and sets WR_ERR.
  - ABORT and CLR_STATUS act normally; CLR_STATUS does not clear BUSY.
- ABORT written in IDLE or DRAIN: no effect.
- GO and CLR_STATUS in the same write: GO wins, and status is cleared by the GO.
- disp_done high while IDLE (spurious): ignored.
- Reset mid-run: everything returns to reset values immediately; disp_reset_n is held 1 and the dispatcher is reset by the shared system reset.

Decomposition:
- Shared package gpu_pkg holds:
  - launcher_state_t enum {IDLE, RUN, DRAIN, ABORT};
  - register address localparams;
  - CONTROL and STATUS bit index localparams.
- One natural sub-module: sat_counter, a CYC_WIDTH saturating counter with clear and enable inputs, used for run_cycles.

Test Plan:
1. Write TC=10, GO at cycle 5 -> disp_start=1 at cycle 6, disp_thread_count=10. Model dispatcher asserts disp_done at cycle 20 -> disp_start=0 at 21, DRAIN exit, STATUS=0x02, irq pulse, run_cycles=15.
2. TC=0, GO -> no disp_start, STATUS DONE=1, irq one pulse, run_cycles=0.
3. TIMEOUT_CYCLES=8, dispatcher never done -> after 8 RUN cycles disp_reset_n low 1 cycle, STATUS=0x08, irq pulse, state IDLE.
4. Mid-run, write THREAD_COUNT=3 then GO -> both ignored, disp_thread_count unchanged, WR_ERR=1 and BUSY=1. Host ABORT -> disp_reset_n low 1 cycle, STATUS ABORTED|WR_ERR=0x14.
5. Same cycle disp_done=1 and ABORT write -> completes as DONE (0x02), disp_reset_n never low.
6. Assert reset low mid-RUN asynchronously -> disp_start=0 and STATUS=0 immediately. After release, a fresh GO with TC=4 behaves as in scenario 1.
